// File: rtl/ascii_pkg.sv
// Shared constants and state type for the ASCII decimal-string parser.
package ascii_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    ERR,
    DONE
  } state_e;

endpackage

// File: rtl/ascii_dec_parser_if.sv
// Character-in / value-out handshake bundle of the ASCII decimal parser.
interface ascii_dec_parser_if #(
  parameter int unsigned OUT_W = 20,
  parameter int unsigned CNT_W = 3
);

  logic [7:0]       char_in;
  logic             char_valid;
  logic             char_ready;
  logic [OUT_W-1:0] value_out;
  logic             value_valid;
  logic             value_ready;
  logic             error;
  logic             overflow;
  logic [CNT_W-1:0] digit_count;

  // Upstream character source that also consumes the converted value.
  modport master (
    output char_in, char_valid, value_ready,
    input  char_ready, value_out, value_valid, error, overflow, digit_count
  );

  modport slave (
    input  char_in, char_valid, value_ready,
    output char_ready, value_out, value_valid, error, overflow, digit_count
  );

endinterface

// File: rtl/ascii_digit_class.sv
// Combinational ASCII classifier: decimal digit, line terminator, digit value.
module ascii_digit_class
  import ascii_pkg::*;
(
  input  logic [7:0] char_in,
  output logic       is_digit,
  output logic       is_term,
  output logic [3:0] digit
);

  always_comb begin
    is_digit = (char_in >= ASCII_ZERO) && (char_in <= ASCII_NINE);
    is_term  = (char_in == ASCII_CR) || (char_in == ASCII_LF);
    // Low nibble of 0x30..0x39 is the digit value; don't-care otherwise.
    digit    = char_in[3:0];
  end

endmodule

// File: rtl/ascii_dec_parser.sv
// Serial ASCII decimal-string to binary converter with illegal-character and
// overflow flags, one character per handshake, result on a valid/ready port.
module ascii_dec_parser
  import ascii_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = 6,
  parameter int unsigned OUT_W      = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  ascii_dec_parser_if.slave  bus
);

  localparam int unsigned CntW  = $clog2(MAX_DIGITS + 1);
  localparam int unsigned ProdW = OUT_W + 4;

  state_e           state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;

  logic             is_digit, is_term;
  logic [3:0]       digit;
  logic [ProdW-1:0] acc_ext, prod;
  logic             prod_ovf, cnt_full, accept;

  ascii_digit_class u_class (
    .char_in  (bus.char_in),
    .is_digit (is_digit),
    .is_term  (is_term),
    .digit    (digit)
  );

  // acc*10 + digit with four guard bits; anything in the guard bits overflows.
  assign acc_ext  = {4'b0000, acc_q};
  assign prod     = (acc_ext << 3) + (acc_ext << 1) + ProdW'(digit);
  assign prod_ovf = |prod[ProdW-1:OUT_W];
  assign cnt_full = (cnt_q == CntW'(MAX_DIGITS));
  assign accept   = bus.char_valid && bus.char_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_digit) begin
            acc_d   = OUT_W'(digit);
            cnt_d   = CntW'(1);
            state_d = ACCUM;
          end else if (!is_term) begin
            err_d   = 1'b1;
            state_d = ERR;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          if (is_digit) begin
            if (cnt_full || prod_ovf) begin
              ovf_d   = 1'b1;
              state_d = ERR;
            end else begin
              acc_d = prod[OUT_W-1:0];
              cnt_d = cnt_q + CntW'(1);
            end
          end else if (is_term) begin
            state_d = DONE;
          end else begin
            err_d   = 1'b1;
            state_d = ERR;
          end
        end
      end
      ERR: begin
        // First fault cause is already latched; only a terminator matters now.
        if (accept && is_term) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.value_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.char_ready  = (state_q != DONE);
  assign bus.value_valid = (state_q == DONE);
  assign bus.value_out   = ((state_q == DONE) && !err_q && !ovf_q) ? acc_q : '0;
  assign bus.error       = err_q;
  assign bus.overflow    = ovf_q;
  assign bus.digit_count = cnt_q;

endmodule

// File: tb/tb_ascii_dec_parser.sv
// Bench for ascii_dec_parser: two instances (OUT_W 20 and 8) share one stream.
module tb_ascii_dec_parser;

  typedef struct {
    longint val;
    bit     err;
    bit     ovf;
    int     cnt;
  } res_t;

  typedef struct {
    res_t a;
    res_t b;
  } exp_t;

  typedef struct {
    string s;
    res_t  a;
    res_t  b;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  bit   rand_rdy = 1'b0;
  exp_t exp_q[$];

  ascii_dec_parser_if #(.OUT_W(20), .CNT_W(3)) bus_a ();
  ascii_dec_parser_if #(.OUT_W(8),  .CNT_W(3)) bus_b ();

  assign bus_b.char_in     = bus_a.char_in;
  assign bus_b.char_valid  = bus_a.char_valid;
  assign bus_b.value_ready = bus_a.value_ready;

  ascii_dec_parser #(.MAX_DIGITS(6), .OUT_W(20)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  ascii_dec_parser #(.MAX_DIGITS(6), .OUT_W(8)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endfunction

  // Reference: evaluate one number's characters (terminator excluded) by the rules.
  function automatic res_t model(input logic [7:0] q[$], input int w, input int maxd);
    res_t   r;
    longint v = 0;
    longint nv;
    longint lim = (longint'(1) << w) - 1;
    r = '{0, 1'b0, 1'b0, 0};
    foreach (q[i]) begin
      if (q[i] < 8'h30 || q[i] > 8'h39) begin
        r.err = 1'b1;
        break;
      end
      if (r.cnt == maxd) begin
        r.ovf = 1'b1;
        break;
      end
      nv = v * 10 + longint'(q[i] - 8'h30);
      if (nv > lim) begin
        r.ovf = 1'b1;
        break;
      end
      v = nv;
      r.cnt++;
    end
    r.val = (r.err || r.ovf) ? 0 : v;
    return r;
  endfunction

  function automatic vec_t mk(input string s, input longint av, input bit ae, input bit ao,
                              input int ac, input longint bv, input bit be, input bit bo,
                              input int bc);
    vec_t t;
    t.s = s;
    t.a = '{av, ae, ao, ac};
    t.b = '{bv, be, bo, bc};
    return t;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] c);
    int t = 0;
    bus_a.char_in    = c;
    bus_a.char_valid = 1'b1;
    forever begin
      if (bus_a.char_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      if (rand_rdy) bus_a.value_ready = ($urandom_range(0, 1) == 1);
      @(posedge clk);
      #1;
      t++;
      if (t > 200) begin
        chk("char_accept_timeout", 0, 1);
        break;
      end
    end
    bus_a.char_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus_a.value_valid && bus_a.value_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("a_value",    bus_a.value_out,   e.a.val);
        chk("a_error",    bus_a.error,       e.a.err);
        chk("a_overflow", bus_a.overflow,    e.a.ovf);
        chk("a_count",    bus_a.digit_count, e.a.cnt);
        chk("b_valid",    bus_b.value_valid, 1);
        chk("b_value",    bus_b.value_out,   e.b.val);
        chk("b_error",    bus_b.error,       e.b.err);
        chk("b_overflow", bus_b.overflow,    e.b.ovf);
        chk("b_count",    bus_b.digit_count, e.b.cnt);
      end
    end
  end

  initial begin
    vec_t        tbl[10];
    logic [7:0]  tok[$];
    logic [7:0]  c;
    exp_t        e;

    tbl[0] = mk("123\015",      123, 0, 0, 3,   123, 0, 0, 3);
    tbl[1] = mk("9999999\n",      0, 0, 1, 6,     0, 0, 1, 2);
    tbl[2] = mk("256\015",      256, 0, 0, 3,     0, 0, 1, 2);
    tbl[3] = mk("255\015",      255, 0, 0, 3,   255, 0, 0, 3);
    tbl[4] = mk("4x2\015",        0, 1, 0, 1,     0, 1, 0, 1);
    tbl[5] = mk("x\n",            0, 1, 0, 0,     0, 1, 0, 0);
    tbl[6] = mk("000042\015",    42, 0, 0, 6,    42, 0, 0, 6);
    tbl[7] = mk("999999\015", 999999, 0, 0, 6,    0, 0, 1, 2);
    tbl[8] = mk("25a5\n",         0, 1, 0, 2,     0, 1, 0, 2);
    tbl[9] = mk("9999999x\n",     0, 0, 1, 6,     0, 0, 1, 2);

    bus_a.char_in     = 8'h00;
    bus_a.char_valid  = 1'b0;
    bus_a.value_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_char_ready",  bus_a.char_ready,  1);
    chk("rst_value_valid", bus_a.value_valid, 0);
    chk("rst_value_out",   bus_a.value_out,   0);
    chk("rst_error",       bus_a.error,       0);
    chk("rst_overflow",    bus_a.overflow,    0);
    chk("rst_digit_count", bus_a.digit_count, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table, consumer always ready: result visible for exactly one cycle.
    bus_a.value_ready = 1'b1;
    foreach (tbl[i]) begin
      e.a = tbl[i].a;
      e.b = tbl[i].b;
      exp_q.push_back(e);
      send_str(tbl[i].s);
      chk("lat_valid_after_term", bus_a.value_valid, 1);
      chk("lat_char_ready_low", bus_a.char_ready, 0);
      @(posedge clk);
      #1;
      chk("lat_valid_dropped", bus_a.value_valid, 0);
      chk("lat_char_ready_back", bus_a.char_ready, 1);
    end

    // Empty lines produce nothing; then a held result under backpressure.
    bus_a.value_ready = 1'b0;
    send(8'h0D);
    send(8'h0A);
    chk("empty_no_valid", bus_a.value_valid, 0);
    send_str("7\015");
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid",      bus_a.value_valid, 1);
      chk("hold_value",      bus_a.value_out,   7);
      chk("hold_count",      bus_a.digit_count, 1);
      chk("hold_char_ready", bus_a.char_ready,  0);
      @(posedge clk);
      #1;
    end
    e.a = '{7, 1'b0, 1'b0, 1};
    e.b = '{7, 1'b0, 1'b0, 1};
    exp_q.push_back(e);
    bus_a.value_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hs_valid_low",   bus_a.value_valid, 0);
    chk("hs_char_ready",  bus_a.char_ready,  1);

    // Reset in mid-number aborts it.
    send_str("56");
    rst_n = 1'b0;
    #1;
    chk("abort_count_cleared", bus_a.digit_count, 0);
    chk("abort_char_ready",    bus_a.char_ready,  1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    e.a = '{8, 1'b0, 1'b0, 1};
    e.b = '{8, 1'b0, 1'b0, 1};
    exp_q.push_back(e);
    send_str("8\015");
    @(posedge clk);
    #1;

    // Random numbers with random consumer backpressure.
    rand_rdy = 1'b1;
    for (int n = 0; n < 150; n++) begin
      int len;
      tok.delete();
      len = $urandom_range(0, 8);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 9) != 0) begin
          c = 8'h30 + 8'($urandom_range(0, 9));
        end else begin
          do c = 8'($urandom_range(0, 255));
          while ((c >= 8'h30 && c <= 8'h39) || c == 8'h0D || c == 8'h0A);
        end
        tok.push_back(c);
      end
      if (tok.size() > 0) begin
        e.a = model(tok, 20, 6);
        e.b = model(tok, 8, 6);
        exp_q.push_back(e);
      end
      foreach (tok[k]) begin
        bus_a.value_ready = ($urandom_range(0, 1) == 1);
        send(tok[k]);
      end
      send(($urandom_range(0, 1) == 1) ? 8'h0D : 8'h0A);
    end
    rand_rdy = 1'b0;
    bus_a.value_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("results_outstanding", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
